// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX requester arbiter.
package uart_pkg;

  localparam int unsigned CNT_W = 8;

  // Arbiter FSM: IDLE picks an owner, OWN forwards that owner's bytes.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Round-robin pick over up to 8 requesters: first set bit of req at or
  // above ptr, wrapping modulo n. Returns ptr when nothing is requesting.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    logic [2:0]  cand;
    int unsigned c;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) begin
        c    = (32'(ptr) + i) % n;
        cand = 3'(c);
        if (!found && req[cand]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin priority pick, shared by TX arbiter and RX dispatcher.
module rr_arbiter_core
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [7:0] req_ext;
  logic [2:0] ptr_ext;

  // Widen to the helper's fixed 8-way width and pick from ptr upward.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    ptr_ext                = 3'(ptr_i);
    idx_o                  = ID_W'(rr_pick(req_ext, ptr_ext, NUM_REQ));
    any_o                  = |req_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locking round-robin arbiter sharing one UART TX parallel port.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic                 pclk_i,
  input  logic                 prst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_pdata_o,
  output logic                 tx_pdata_valid_o,
  input  logic                 tx_pready_i,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 busy_o,
  output logic                 forced_rel_o
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             busy_q, busy_d;
  logic             forced_q, forced_d;

  logic [7:0]       req_bytes [NUM_REQ];
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             own_valid;
  logic             own_last;
  logic             xfer;
  logic             release_now;
  logic [CNT_W-1:0] burst_inc;
  logic [CNT_W-1:0] idle_inc;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Unflatten the requester byte lanes for owner muxing.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = req_data_i[8*k +: 8];
    end
  end

  // Next-state, counters and the owner pass-through mux.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    rr_ptr_d         = rr_ptr_q;
    burst_cnt_d      = burst_cnt_q;
    idle_cnt_d       = idle_cnt_q;
    forced_d         = 1'b0;
    tx_pdata_o       = '0;
    tx_pdata_valid_o = 1'b0;
    req_ready_o      = '0;
    release_now      = 1'b0;
    own_valid        = req_valid_i[gnt_q];
    own_last         = req_last_i[gnt_q];
    xfer             = 1'b0;
    burst_inc        = burst_cnt_q + CNT_W'(1);
    idle_inc         = idle_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_idx;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = OWN;
        end
      end
      OWN: begin
        tx_pdata_o          = req_bytes[gnt_q];
        tx_pdata_valid_o    = own_valid;
        req_ready_o[gnt_q]  = tx_pready_i;
        xfer                = own_valid && tx_pready_i;
        if (xfer) begin
          burst_cnt_d = burst_inc;
          idle_cnt_d  = '0;
          if (own_last) begin
            release_now = 1'b1;
          end else if (burst_inc == CNT_W'(MAX_BURST)) begin
            release_now = 1'b1;
            forced_d    = 1'b1;
          end
        end else if (!own_valid) begin
          idle_cnt_d = idle_inc;
          if (idle_inc == CNT_W'(IDLE_TIMEOUT)) begin
            release_now = 1'b1;
            forced_d    = 1'b1;
          end
        end
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == OWN);
  end

  // State and registered status outputs.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      busy_q      <= 1'b0;
      forced_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      busy_q      <= busy_d;
      forced_q    <= forced_d;
    end
  end

  assign gnt_id_o     = gnt_q;
  assign busy_o       = busy_q;
  assign forced_rel_o = forced_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, transfer log.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;

  logic             pclk_i;
  logic             prst_n_i;
  logic [N-1:0]     req_valid_i;
  logic [N*8-1:0]   req_data_i;
  logic [N-1:0]     req_last_i;
  logic [N-1:0]     req_ready_o;
  logic [7:0]       tx_pdata_o;
  logic             tx_pdata_valid_o;
  logic             tx_pready_i;
  logic [1:0]       gnt_id_o;
  logic             busy_o;
  logic             forced_rel_o;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .ID_W         (2),
    .MAX_BURST    (16),
    .IDLE_TIMEOUT (32)
  ) dut (
    .pclk_i           (pclk_i),
    .prst_n_i         (prst_n_i),
    .req_valid_i      (req_valid_i),
    .req_data_i       (req_data_i),
    .req_last_i       (req_last_i),
    .req_ready_o      (req_ready_o),
    .tx_pdata_o       (tx_pdata_o),
    .tx_pdata_valid_o (tx_pdata_valid_o),
    .tx_pready_i      (tx_pready_i),
    .gnt_id_o         (gnt_id_o),
    .busy_o           (busy_o),
    .forced_rel_o     (forced_rel_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  // Requester source queues.
  logic [7:0] mem [N][64];
  logic       lst [N][64];
  logic [5:0] hd [N];
  logic [5:0] tl [N];

  // Log of bytes accepted by the UART side.
  logic [7:0] log_d  [128];
  logic [1:0] log_id [128];
  int         nlog;

  // Mid-cycle output snapshot.
  logic [N-1:0] s_rdy;
  logic         s_txv;
  logic [7:0]   s_txd;
  logic         s_busy;
  logic [1:0]   s_gnt;
  logic         s_frc;

  int checks;
  int errors;

  task automatic push(input int k, input logic [7:0] d, input logic l);
    mem[k][tl[k]] = d;
    lst[k][tl[k]] = l;
    tl[k]         = tl[k] + 6'd1;
  endtask

  task automatic clear_q();
    for (int k = 0; k < N; k++) begin
      hd[k] = '0;
      tl[k] = '0;
    end
    nlog = 0;
  endtask

  task automatic drive();
    logic [7:0]   b [N];
    logic [N-1:0] v;
    logic [N-1:0] l;
    for (int k = 0; k < N; k++) begin
      v[k] = (hd[k] != tl[k]);
      b[k] = v[k] ? mem[k][hd[k]] : 8'h00;
      l[k] = v[k] ? lst[k][hd[k]] : 1'b0;
    end
    req_valid_i = v;
    req_last_i  = l;
    req_data_i  = {b[3], b[2], b[1], b[0]};
  endtask

  task automatic sample();
    #1;
    s_rdy  = req_ready_o;
    s_txv  = tx_pdata_valid_o;
    s_txd  = tx_pdata_o;
    s_busy = busy_o;
    s_gnt  = gnt_id_o;
    s_frc  = forced_rel_o;
    if (s_txv && tx_pready_i && s_busy) begin
      log_d[nlog]  = s_txd;
      log_id[nlog] = s_gnt;
      nlog++;
    end
    checks++;
    if (!$onehot0(s_rdy)) begin
      errors++;
      $display("FAIL ready_onehot: got %b required at most one bit", s_rdy);
    end
    for (int k = 0; k < N; k++) begin
      if (s_rdy[k] && req_valid_i[k]) hd[k] = hd[k] + 6'd1;
    end
  endtask

  // One clock cycle: drive at the falling edge, observe, advance.
  task automatic tick();
    drive();
    sample();
    @(negedge pclk_i);
  endtask

  task automatic do_reset();
    prst_n_i    = 1'b0;
    tx_pready_i = 1'b1;
    clear_q();
    drive();
    repeat (2) @(negedge pclk_i);
    prst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    prst_n_i    = 1'b1;
    tx_pready_i = 1'b1;
    clear_q();
    drive();
    #2 prst_n_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 4'b0)    begin errors++; $display("FAIL rst_ready: got %b required 0", req_ready_o); end
    checks++; if (tx_pdata_o !== 8'h00)     begin errors++; $display("FAIL rst_pdata: got %h required 00", tx_pdata_o); end
    checks++; if (tx_pdata_valid_o !== 1'b0) begin errors++; $display("FAIL rst_pvalid: got %b required 0", tx_pdata_valid_o); end
    checks++; if (gnt_id_o !== 2'd0)        begin errors++; $display("FAIL rst_gnt: got %0d required 0", gnt_id_o); end
    checks++; if (busy_o !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b required 0", busy_o); end
    checks++; if (forced_rel_o !== 1'b0)    begin errors++; $display("FAIL rst_forced: got %b required 0", forced_rel_o); end
    @(negedge pclk_i);
    prst_n_i = 1'b1;
  endtask

  task automatic test_single_frame();
    do_reset();
    push(0, 8'hA5, 1'b0);
    push(0, 8'h3C, 1'b1);
    tick();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL sf_idle_busy: got %b required 0", s_busy); end
    checks++; if (s_rdy !== 4'b0)  begin errors++; $display("FAIL sf_idle_ready: got %b required 0", s_rdy); end
    tick();
    checks++; if (s_gnt !== 2'd0)  begin errors++; $display("FAIL sf_gnt: got %0d required 0", s_gnt); end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL sf_busy: got %b required 1", s_busy); end
    checks++; if (s_txd !== 8'hA5) begin errors++; $display("FAIL sf_byte0: got %h required a5", s_txd); end
    tick();
    checks++; if (s_txd !== 8'h3C) begin errors++; $display("FAIL sf_byte1: got %h required 3c", s_txd); end
    tick();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL sf_release_busy: got %b required 0", s_busy); end
    checks++; if (s_frc !== 1'b0)  begin errors++; $display("FAIL sf_forced: got %b required 0", s_frc); end
    checks++; if (nlog !== 2)      begin errors++; $display("FAIL sf_count: got %0d required 2", nlog); end
    // rr_ptr now 1: with 0 and 1 both requesting, 1 must win.
    push(0, 8'h55, 1'b1);
    push(1, 8'h66, 1'b1);
    tick();
    tick();
    checks++; if (s_gnt !== 2'd1)  begin errors++; $display("FAIL sf_rrptr_gnt: got %0d required 1", s_gnt); end
    checks++; if (s_txd !== 8'h66) begin errors++; $display("FAIL sf_rrptr_byte: got %h required 66", s_txd); end
  endtask

  task automatic test_round_robin();
    logic [7:0] ed [5];
    logic [1:0] ei [5];
    ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    ei = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    push(0, 8'h10, 1'b1);
    push(0, 8'h20, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    for (int t = 0; t < 11; t++) begin
      tick();
      checks++;
      if (s_busy !== ((t % 2) == 1)) begin
        errors++;
        $display("FAIL rr_busy_t%0d: got %b required %b", t, s_busy, ((t % 2) == 1));
      end
    end
    checks++; if (nlog !== 5) begin errors++; $display("FAIL rr_count: got %0d required 5", nlog); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_id[i] !== ei[i] || log_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL rr_grant%0d: got id %0d byte %h required id %0d byte %h",
                 i, log_id[i], log_d[i], ei[i], ed[i]);
      end
    end
  endtask

  task automatic test_burst_cap();
    logic frc_a [20];
    int   run;
    logic stop;
    do_reset();
    for (int i = 0; i < 20; i++) push(2, 8'(8'h40 + i), 1'b0);
    tick();
    push(1, 8'h77, 1'b1);
    for (int t = 1; t < 19; t++) begin
      tick();
      frc_a[t] = s_frc;
    end
    run  = 0;
    stop = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (i < nlog && !stop) begin
        if (log_id[i] == 2'd2) run++;
        else stop = 1'b1;
      end
    end
    checks++; if (run !== 16)            begin errors++; $display("FAIL cap_transfers: got %0d required 16", run); end
    checks++; if (log_d[15] !== 8'h4F)   begin errors++; $display("FAIL cap_last_byte: got %h required 4f", log_d[15]); end
    checks++; if (frc_a[16] !== 1'b0)    begin errors++; $display("FAIL cap_forced_early: got %b required 0", frc_a[16]); end
    checks++; if (frc_a[17] !== 1'b1)    begin errors++; $display("FAIL cap_forced_pulse: got %b required 1", frc_a[17]); end
    checks++; if (frc_a[18] !== 1'b0)    begin errors++; $display("FAIL cap_forced_width: got %b required 0", frc_a[18]); end
    checks++; if (nlog !== 17 || log_id[16] !== 2'd1 || log_d[16] !== 8'h77) begin
      errors++;
      $display("FAIL cap_next_grant: got n %0d id %0d byte %h required n 17 id 1 byte 77",
               nlog, log_id[16], log_d[16]);
    end
  endtask

  task automatic test_timeout();
    logic busy_a [36];
    logic frc_a  [36];
    do_reset();
    push(3, 8'h5A, 1'b0);
    for (int t = 0; t < 36; t++) begin
      tick();
      busy_a[t] = s_busy;
      frc_a[t]  = s_frc;
    end
    checks++; if (busy_a[1] !== 1'b1)  begin errors++; $display("FAIL to_busy_start: got %b required 1", busy_a[1]); end
    checks++; if (busy_a[33] !== 1'b1) begin errors++; $display("FAIL to_busy_held: got %b required 1", busy_a[33]); end
    checks++; if (busy_a[34] !== 1'b0) begin errors++; $display("FAIL to_release: got %b required 0", busy_a[34]); end
    checks++; if (frc_a[33] !== 1'b0)  begin errors++; $display("FAIL to_forced_early: got %b required 0", frc_a[33]); end
    checks++; if (frc_a[34] !== 1'b1)  begin errors++; $display("FAIL to_forced_pulse: got %b required 1", frc_a[34]); end
    checks++; if (frc_a[35] !== 1'b0)  begin errors++; $display("FAIL to_forced_width: got %b required 0", frc_a[35]); end
    checks++; if (nlog !== 1 || log_d[0] !== 8'h5A || log_id[0] !== 2'd3) begin
      errors++;
      $display("FAIL to_byte: got n %0d byte %h id %0d required n 1 byte 5a id 3",
               nlog, log_d[0], log_id[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    tick();
    tick();
    tx_pready_i = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++; if (s_rdy !== 4'b0)  begin errors++; $display("FAIL bp_ready_c%0d: got %b required 0", t, s_rdy); end
      checks++; if (s_txd !== 8'hB2 || s_txv !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got %h/%b required b2/1", t, s_txd, s_txv);
      end
      checks++; if (dut.burst_cnt_q !== 8'd1 || dut.idle_cnt_q !== 8'd0) begin
        errors++;
        $display("FAIL bp_counters_c%0d: got burst %0d idle %0d required 1 0",
                 t, dut.burst_cnt_q, dut.idle_cnt_q);
      end
    end
    tx_pready_i = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (s_busy !== 1'b0 || s_frc !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got busy %b forced %b required 0 0", s_busy, s_frc);
    end
    checks++; if (nlog !== 3 || log_d[0] !== 8'hB1 || log_d[1] !== 8'hB2 || log_d[2] !== 8'hB3) begin
      errors++;
      $display("FAIL bp_bytes: got n %0d %h %h %h required 3 b1 b2 b3",
               nlog, log_d[0], log_d[1], log_d[2]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2, 8'hC1, 1'b0);
    push(2, 8'hC2, 1'b0);
    push(2, 8'hC3, 1'b1);
    tick();
    tick();
    drive();
    #1;
    checks++; if (busy_o !== 1'b1 || tx_pdata_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre: got busy %b valid %b required 1 1", busy_o, tx_pdata_valid_o);
    end
    #1 prst_n_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 4'b0 || tx_pdata_valid_o !== 1'b0 || tx_pdata_o !== 8'h00) begin
      errors++;
      $display("FAIL rm_tx_outputs: got %b %b %h required 0 0 00", req_ready_o, tx_pdata_valid_o, tx_pdata_o);
    end
    checks++; if (busy_o !== 1'b0 || gnt_id_o !== 2'd0 || forced_rel_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_status: got busy %b gnt %0d forced %b required 0 0 0", busy_o, gnt_id_o, forced_rel_o);
    end
    @(negedge pclk_i);
    prst_n_i = 1'b1;
    push(1, 8'hD1, 1'b1);
    push(3, 8'hE1, 1'b1);
    tick();
    tick();
    checks++; if (s_gnt !== 2'd1 || s_txd !== 8'hD1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_first_grant: got gnt %0d byte %h busy %b required 1 d1 1", s_gnt, s_txd, s_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_burst_cap();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
